// File: rtl/operand_hazard_ctrl_pkg.sv
// Shared operand-mux select encodings for the DOF stage.
// Used by the hazard controller and by the bus A / bus B operand muxes.
package operand_hazard_ctrl_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_PC  = 2'b01;
    localparam logic [1:0] SEL_FWD = 2'b10;

endpackage

// File: rtl/operand_hazard_ctrl.sv
// DOF-stage hazard/forwarding controller: forwards the EX result on RAW hits, inserts a one-cycle
// load-use stall, cancels the DOF instruction on a taken branch and counts stall cycles.
module operand_hazard_ctrl
    import operand_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dof_valid,
    input  logic [REG_AW-1:0] dof_aa,
    input  logic [REG_AW-1:0] dof_ba,
    input  logic              dof_ma,
    input  logic              dof_mb,
    input  logic              dof_rw,
    input  logic [REG_AW-1:0] dof_da,
    input  logic              dof_load,
    input  logic              branch_taken,
    output logic [1:0]        selA,
    output logic [1:0]        selB,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    // Shadow of the instruction currently in EX
    logic              r_ex_valid;
    logic              r_ex_rw;
    logic              r_ex_load;
    logic [REG_AW-1:0] r_ex_da;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_zero_a;
    logic w_zero_b;
    logic w_hit_a;
    logic w_hit_b;
    logic w_lu;
    logic w_stall;
    logic w_bubble;

    always_comb begin
        w_zero_a = ZERO_REG && (dof_aa == '0);
        w_zero_b = ZERO_REG && (dof_ba == '0);
        w_hit_a  = dof_valid && !dof_ma && r_ex_valid && r_ex_rw && (dof_aa == r_ex_da) && !w_zero_a;
        w_hit_b  = dof_valid && !dof_mb && r_ex_valid && r_ex_rw && (dof_ba == r_ex_da) && !w_zero_b;

        // Immediate/PC selection always wins over forwarding
        selA = SEL_REG;
        if (dof_ma) begin
            selA = SEL_PC;
        end else if (w_hit_a && !r_ex_load) begin
            selA = SEL_FWD;
        end

        selB = SEL_REG;
        if (dof_mb) begin
            selB = SEL_PC;
        end else if (w_hit_b && !r_ex_load) begin
            selB = SEL_FWD;
        end

        // A taken branch makes the DOF instruction wrong-path, so it never stalls
        w_lu     = (w_hit_a || w_hit_b) && r_ex_load;
        w_stall  = w_lu && !branch_taken;
        w_bubble = w_stall || branch_taken;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rw       <= 1'b0;
            r_ex_load     <= 1'b0;
            r_ex_da       <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_rw    <= 1'b0;
                r_ex_load  <= 1'b0;
            end else begin
                r_ex_valid <= dof_valid;
                r_ex_rw    <= dof_rw && dof_valid;
                r_ex_load  <= dof_load && dof_valid;
                r_ex_da    <= dof_da;
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall       = w_stall;
    assign bubble      = w_bubble;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Self-checking bench for operand_hazard_ctrl: directed vector table plus reset-mid-stall and
// counter-saturation sequences (saturation exercised on a narrow-counter second instance).
module tb_operand_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic       dof_valid;
    logic [4:0] dof_aa;
    logic [4:0] dof_ba;
    logic       dof_ma;
    logic       dof_mb;
    logic       dof_rw;
    logic [4:0] dof_da;
    logic       dof_load;
    logic       branch_taken;
    logic [1:0] selA;
    logic [1:0] selB;
    logic       stall;
    logic       bubble;
    logic [15:0] stall_count;
    logic [1:0] s_selA;
    logic [1:0] s_selB;
    logic       s_stall;
    logic       s_bubble;
    logic [1:0] s_stall_count;

    int n_checks = 0;
    int n_errors = 0;

    operand_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
        .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_load(dof_load),
        .branch_taken(branch_taken), .selA(selA), .selB(selB), .stall(stall), .bubble(bubble),
        .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a few cycles
    operand_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
        .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da), .dof_load(dof_load),
        .branch_taken(branch_taken), .selA(s_selA), .selB(s_selB), .stall(s_stall),
        .bubble(s_bubble), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       ma;
        logic       mb;
        logic       rw;
        logic [4:0] da;
        logic       load;
        logic       br;
        logic [1:0] e_sela;
        logic [1:0] e_selb;
        logic       e_stall;
        logic       e_bubble;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic valid, input int aa, input int ba,
                                input logic ma, input logic mb, input logic rw, input int da,
                                input logic load, input logic br, input logic [1:0] esa,
                                input logic [1:0] esb, input logic est, input logic ebu,
                                input int ecnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.aa = 5'(aa); v.ba = 5'(ba); v.ma = ma; v.mb = mb;
        v.rw = rw; v.da = 5'(da); v.load = load; v.br = br;
        v.e_sela = esa; v.e_selb = esb; v.e_stall = est; v.e_bubble = ebu; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic valid, input int aa, input int ba,
                         input logic ma, input logic mb, input logic rw, input int da,
                         input logic load, input logic br);
        reset_n = ~rst; dof_valid = valid; dof_aa = 5'(aa); dof_ba = 5'(ba);
        dof_ma = ma; dof_mb = mb; dof_rw = rw; dof_da = 5'(da); dof_load = load;
        branch_taken = br;
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        //          rst  vld  aa  ba  ma   mb   rw   da  ld   br   selA   selB   st   bu  cnt
        tbl.push_back(mk(1, 0,  0,  0, 1, 0, 0,  0, 0, 0, 2'b01, 2'b00, 0, 0, 0)); // reset, ma
        tbl.push_back(mk(0, 1,  1,  2, 0, 0, 1,  3, 0, 0, 2'b00, 2'b00, 0, 0, 0)); // ADD R3
        tbl.push_back(mk(0, 1,  3,  3, 0, 0, 1,  5, 0, 0, 2'b10, 2'b10, 0, 0, 0)); // use R3,R3
        tbl.push_back(mk(0, 1,  5,  5, 0, 1, 1,  7, 0, 0, 2'b10, 2'b01, 0, 0, 0)); // mb wins
        tbl.push_back(mk(0, 1,  1,  0, 0, 1, 1,  4, 1, 0, 2'b00, 2'b01, 0, 0, 0)); // LD R4
        tbl.push_back(mk(0, 1,  4,  1, 0, 0, 1,  6, 0, 0, 2'b00, 2'b00, 1, 1, 0)); // load-use
        tbl.push_back(mk(0, 1,  4,  1, 0, 0, 1,  6, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // after stall
        tbl.push_back(mk(0, 1,  1,  2, 0, 0, 1,  0, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // ADD R0
        tbl.push_back(mk(0, 1,  0,  0, 0, 0, 1,  8, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // use R0
        tbl.push_back(mk(0, 1,  1,  0, 0, 1, 1,  0, 1, 0, 2'b00, 2'b01, 0, 0, 1)); // LD R0
        tbl.push_back(mk(0, 1,  0,  0, 0, 0, 1,  9, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // no stall R0
        tbl.push_back(mk(0, 1,  2,  0, 0, 1, 1,  4, 1, 0, 2'b00, 2'b01, 0, 0, 1)); // LD R4
        tbl.push_back(mk(0, 1,  1,  4, 0, 0, 1, 10, 0, 1, 2'b00, 2'b00, 0, 1, 1)); // use + branch
        tbl.push_back(mk(0, 1,  4, 10, 0, 0, 1, 11, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // flushed EX
        tbl.push_back(mk(0, 1, 11, 11, 1, 0, 1, 12, 0, 0, 2'b01, 2'b10, 0, 0, 1)); // ma wins, B fwd
        tbl.push_back(mk(0, 0, 12, 12, 0, 0, 1, 13, 1, 0, 2'b00, 2'b00, 0, 0, 1)); // DOF bubble
        tbl.push_back(mk(0, 1, 13, 13, 0, 0, 1, 14, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // EX invalid
        tbl.push_back(mk(0, 1,  1,  2, 0, 0, 0, 15, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // no-write inst
        tbl.push_back(mk(0, 1, 15, 15, 0, 0, 0, 15, 0, 0, 2'b00, 2'b00, 0, 0, 1)); // EX rw=0
        tbl.push_back(mk(0, 1,  1,  0, 0, 1, 1, 16, 1, 0, 2'b00, 2'b01, 0, 0, 1)); // LD R16
        tbl.push_back(mk(0, 1, 16, 16, 0, 0, 1, 17, 0, 0, 2'b00, 2'b00, 1, 1, 1)); // both hit load
        tbl.push_back(mk(0, 1, 16, 16, 0, 0, 1, 17, 0, 0, 2'b00, 2'b00, 0, 0, 2)); // one stall only

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst, tbl[i].valid, int'(tbl[i].aa), int'(tbl[i].ba), tbl[i].ma,
                  tbl[i].mb, tbl[i].rw, int'(tbl[i].da), tbl[i].load, tbl[i].br);
            @(negedge clk);
            chk($sformatf("v%0d selA", i), int'(selA), int'(tbl[i].e_sela));
            chk($sformatf("v%0d selB", i), int'(selB), int'(tbl[i].e_selb));
            chk($sformatf("v%0d stall", i), int'(stall), int'(tbl[i].e_stall));
            chk($sformatf("v%0d bubble", i), int'(bubble), int'(tbl[i].e_bubble));
            chk($sformatf("v%0d count", i), int'(stall_count), tbl[i].e_cnt);
        end

        // Reset asserted in the middle of a stall cycle cancels it immediately
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1, 0, 1'b0, 1'b1, 1'b1, 20, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 20, 1, 1'b0, 1'b0, 1'b1, 21, 1'b0, 1'b0);
        @(negedge clk);
        chk("midstall stall", int'(stall), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("midstall rst stall", int'(stall), 0);
        chk("midstall rst bubble", int'(bubble), 0);
        chk("midstall rst count", int'(stall_count), 0);
        chk("midstall rst selA", int'(selA), 0);

        // Repeated load-use stalls: narrow counter saturates at 3, wide one keeps counting
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b0);
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 3, 20, 1'b0, 1'b0, 1'b1, 21, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("sat%0d stall", k), int'(s_stall), 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("sat%0d nostall", k), int'(s_stall), 0);
            chk($sformatf("sat%0d small cnt", k), int'(s_stall_count), (k < 3) ? k : 3);
            chk($sformatf("sat%0d wide cnt", k), int'(stall_count), k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
